// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the fetch and decode stages: the fixed PC vectors,
// the instruction word injected on a flush, the field layout of the 64-bit
// IF_ID pipeline register, the next-PC source encoding and the incrementer
// that keeps the kernel-mode bit.
// ---------------------------------------------------------------------------
package if_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;  // PC after reset, kernel mode
    localparam logic [31:0] ILLOP_PC = 32'h8000_0004;  // interrupt vector
    localparam logic [31:0] XADR_PC  = 32'h8000_0008;  // undefined-instruction vector
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;  // bubble instruction

    // IF_ID field layout: instruction in the low word, its PC+4 in the high word
    localparam int IF_ID_W  = 64;
    localparam int INSN_LSB = 0;
    localparam int INSN_MSB = 31;
    localparam int PCP4_LSB = 32;
    localparam int PCP4_MSB = 63;

    // Source of the next PC, listed in priority order
    typedef enum logic [2:0] {
        SEL_INT,
        SEL_EXC,
        SEL_HOLD,
        SEL_JR,
        SEL_J,
        SEL_BR,
        SEL_SEQ
    } pc_sel_e;

    // The kernel bit (PC[31]) is never carried into; the low 31 bits wrap.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// ---------------------------------------------------------------------------
// if_next_pc
// Combinational next-PC selection for the fetch stage.
// Ports:
//   i_pc            current PC
//   i_z/i_j/i_jr    decode redirects (branch taken, jump, register jump)
//   i_write         0 = load-use stall
//   i_branch_target/i_jump_target/i_jr_target  redirect targets
//   i_interrupt     take interrupt vector
//   i_exception     take undefined-instruction vector
//   o_pc_next       PC to load at the next edge
//   o_pc_plus4      sequential PC (kernel bit preserved)
//   o_flush         IF_ID must be loaded with a bubble
//   o_hold          PC, IF_ID and last_PC_plus4 keep their values
// ---------------------------------------------------------------------------
module if_next_pc
    import if_stage_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_z,
    input  logic        i_j,
    input  logic        i_jr,
    input  logic        i_write,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jump_target,
    input  logic [31:0] i_jr_target,
    input  logic        i_interrupt,
    input  logic        i_exception,
    output logic [31:0] o_pc_next,
    output logic [31:0] o_pc_plus4,
    output logic        o_flush,
    output logic        o_hold
);

    pc_sel_e     w_sel;
    logic [31:0] w_br_pc;

    assign o_pc_plus4 = pc_inc(i_pc);

    // A taken branch keeps the current mode: low 31 bits from the target,
    // bit 31 from the current PC.
    assign w_br_pc = (i_branch_target & 32'h7FFF_FFFF) | (i_pc & 32'h8000_0000);

    // Priority: interrupt and exception override a stall; a stall masks
    // the decode redirects so the stalled instruction resolves again.
    always_comb begin
        w_sel = SEL_SEQ;
        if (i_interrupt)      w_sel = SEL_INT;
        else if (i_exception) w_sel = SEL_EXC;
        else if (!i_write)    w_sel = SEL_HOLD;
        else if (i_jr)        w_sel = SEL_JR;
        else if (i_j)         w_sel = SEL_J;
        else if (i_z)         w_sel = SEL_BR;
    end

    always_comb begin
        o_pc_next = o_pc_plus4;
        o_flush   = 1'b1;
        o_hold    = 1'b0;
        case (w_sel)
            SEL_INT:  o_pc_next = ILLOP_PC;
            SEL_EXC:  o_pc_next = XADR_PC;
            SEL_HOLD: begin
                o_pc_next = i_pc;
                o_flush   = 1'b0;
                o_hold    = 1'b1;
            end
            SEL_JR:   o_pc_next = i_jr_target;
            SEL_J:    o_pc_next = i_jump_target;
            SEL_BR:   o_pc_next = w_br_pc;
            default: begin
                o_pc_next = o_pc_plus4;
                o_flush   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: holds the PC, addresses the instruction ROM,
// chooses the next PC from decode's redirect/stall controls and loads the
// IF_ID register consumed by decode.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   imem_addr         ROM address (= PC)
//   imem_rdata        ROM word for imem_addr, same cycle
//   Z, J, JR          decode redirects: branch taken, jump, register jump
//   PC_IF_ID_Write    0 = load-use stall
//   branch_target, jump_target, jr_target   redirect targets
//   interrupt, exception                    vector to ILLOP / XADR
//   IF_ID             {PC+4, instruction} delivered to decode
//   last_PC_plus4     IF_ID PC+4 field before the most recent IF_ID update
//   fetch_count       instructions delivered (not bubbles, not stalls)
// ---------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        Z,
    input  logic        J,
    input  logic        JR,
    input  logic        PC_IF_ID_Write,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        interrupt,
    input  logic        exception,
    output logic [63:0] IF_ID,
    output logic [31:0] last_PC_plus4,
    output logic [31:0] fetch_count
);

    logic [31:0]        r_pc;
    logic [IF_ID_W-1:0] r_if_id;
    logic [31:0]        r_last_pcp4;
    logic [31:0]        r_fetch_count;

    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic        w_flush;
    logic        w_hold;

    if_next_pc u_next_pc (
        .i_pc            (r_pc),
        .i_z             (Z),
        .i_j             (J),
        .i_jr            (JR),
        .i_write         (PC_IF_ID_Write),
        .i_branch_target (branch_target),
        .i_jump_target   (jump_target),
        .i_jr_target     (jr_target),
        .i_interrupt     (interrupt),
        .i_exception     (exception),
        .o_pc_next       (w_pc_next),
        .o_pc_plus4      (w_pc_plus4),
        .o_flush         (w_flush),
        .o_hold          (w_hold)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id       <= {RESET_PC, NOP_INSN};
            r_last_pcp4   <= RESET_PC;
            r_fetch_count <= 32'd0;
        end else if (!w_hold) begin
            r_pc        <= w_pc_next;
            r_last_pcp4 <= r_if_id[PCP4_MSB:PCP4_LSB];
            if (w_flush) begin
                // Bubble carries the redirect target as its PC+4, so an
                // interrupt taken on the bubble returns to the target.
                r_if_id <= {w_pc_next, NOP_INSN};
            end else begin
                r_if_id       <= {w_pc_plus4, imem_rdata};
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr     = r_pc;
    assign IF_ID         = r_if_id;
    assign last_PC_plus4 = r_last_pcp4;
    assign fetch_count   = r_fetch_count;

endmodule
